// File: rtl/button_pio_pkg.sv
// Shared register addresses, edge-type encodings and edge qualification helper
// for the button input PIO.
package button_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

  // True when a stable transition to new_lvl is an edge of the requested type.
  function automatic logic edge_match(input int edge_type, input logic new_lvl);
    case (edge_type)
      int'(EDGE_RISE): edge_match = new_lvl;
      int'(EDGE_FALL): edge_match = !new_lvl;
      default:         edge_match = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// One button input: two-flop synchroniser, hold-time debounce counter,
// stable level flop and a single-cycle qualified edge pulse.
module pio_debounce_bit
  import button_pio_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter int   EDGE_TYPE       = 1,
  parameter logic RESET_VAL       = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic stable,
  output logic edge_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;
  logic             done;

  // Candidate level has been held long enough; stable takes it on this edge.
  assign done       = (sync_p1 != stable) && (cnt == CNT_MAX);
  assign edge_pulse = done && edge_match(EDGE_TYPE, sync_p1);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= RESET_VAL;
      sync_p1 <= RESET_VAL;
      stable  <= RESET_VAL;
      cnt     <= '0;
    end else begin
      sync_p0 <= pin;
      sync_p1 <= sync_p0;
      if (sync_p1 == stable) begin
        cnt <= '0;
      end else if (done) begin
        stable <= sync_p1;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_pio_debounce_rx.sv
// Debounced push-button input PIO with edge capture, interrupt mask and a
// zero-wait-state Avalon-MM slave (DATA / RSVD / MASK / EDGE).
module button_pio_debounce_rx
  import button_pio_pkg::*;
#(
  parameter int               WIDTH           = 1,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] IN_RESET_VAL    = {WIDTH{1'b1}}
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [WIDTH-1:0] button_in,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] edge_pulse;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] edge_cap_nxt;
  logic [WIDTH-1:0] w1c_bits;
  logic [31:0]      rd_mux;
  logic             wr_mask;
  logic             wr_edge;
  logic             unused_wdata;

  assign unused_wdata = ^avs_writedata[31:WIDTH];

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    pio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .EDGE_TYPE      (EDGE_TYPE),
      .RESET_VAL      (IN_RESET_VAL[gi])
    ) u_bit (
      .clk       (clk_clk),
      .rst       (reset_reset),
      .pin       (button_in[gi]),
      .stable    (stable[gi]),
      .edge_pulse(edge_pulse[gi])
    );
  end

  assign wr_mask = avs_write && (avs_address == ADDR_MASK);
  assign wr_edge = avs_write && (avs_address == ADDR_EDGE);

  // A new edge in the same cycle as its W1C must survive, so the set is OR-ed last.
  always_comb begin
    w1c_bits     = wr_edge ? avs_writedata[WIDTH-1:0] : '0;
    edge_cap_nxt = (edge_cap & ~w1c_bits) | edge_pulse;
  end

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_DATA: rd_mux[WIDTH-1:0] = stable;
      ADDR_MASK: rd_mux[WIDTH-1:0] = mask;
      ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_cap;
      default:   rd_mux = '0;
    endcase
  end

  // Read data and irq both sample pre-write register values.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      mask         <= '0;
      edge_cap     <= '0;
      avs_readdata <= '0;
      irq          <= 1'b0;
    end else begin
      if (wr_mask) mask <= avs_writedata[WIDTH-1:0];
      edge_cap <= edge_cap_nxt;
      if (avs_read) avs_readdata <= rd_mux;
      irq <= |(edge_cap & mask);
    end
  end

endmodule

// File: tb/tb_button_pio_debounce_rx.sv
// Bench for button_pio_debounce_rx: bus reads are scored against a queue of
// expected values; irq and reset values are compared directly.
module tb_button_pio_debounce_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  button_in = 2'b11;
  logic [1:0]  avs_address = 2'd0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic        rd_vld = 1'b0;

  always #5 clk = ~clk;

  button_pio_debounce_rx #(
    .WIDTH          (2),
    .DEBOUNCE_CYCLES(8),
    .EDGE_TYPE      (1),
    .IN_RESET_VAL   (2'b11)
  ) dut (
    .clk_clk      (clk),
    .reset_reset  (rst),
    .button_in    (button_in),
    .avs_address  (avs_address),
    .avs_read     (avs_read),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata (avs_readdata),
    .irq          (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) rd_vld <= avs_read;

  always @(negedge clk) begin
    logic [31:0] e;
    string t;
    if (rd_vld) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk(t, avs_readdata, e);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string t);
    avs_address = a;
    avs_read = 1'b1;
    exp_q.push_back(e);
    tag_q.push_back(t);
    step(1);
    avs_read = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    avs_address = a;
    avs_writedata = d;
    avs_write = 1'b1;
    step(1);
    avs_write = 1'b0;
  endtask

  // Back-to-back DATA reads; stable falls on the 10th clock after the change.
  task automatic watch_fall(input string t);
    avs_address = 2'd0;
    for (int j = 0; j < 13; j++) begin
      avs_read = 1'b1;
      exp_q.push_back((j < 10) ? 32'h3 : 32'h2);
      tag_q.push_back($sformatf("%s_%0d", t, j));
      step(1);
    end
    avs_read = 1'b0;
  endtask

  initial begin
    // Reset with buttons released
    step(3);
    rst = 1'b0;
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_rdata", avs_readdata, 32'd0);
    rd(2'd0, 32'h3, "rst_data");
    rd(2'd3, 32'h0, "rst_edge");
    rd(2'd1, 32'h0, "rsvd");
    step(12);
    rd(2'd3, 32'h0, "no_edge_on_release");
    rd(2'd2, 32'h0, "rst_mask");

    // Debounced fall on bit0
    button_in = 2'b10;
    watch_fall("fall_timing");
    step(8);
    rd(2'd3, 32'h1, "edge_fall");
    chk("irq_masked", {31'd0, irq}, 32'd0);

    // Short glitch on bit1
    button_in = 2'b00;
    step(5);
    button_in = 2'b10;
    step(20);
    rd(2'd0, 32'h2, "glitch_data");
    rd(2'd3, 32'h1, "glitch_edge");

    // Mask enable then W1C
    wr(2'd2, 32'h1);
    chk("irq_lag_set", {31'd0, irq}, 32'd0);
    step(1);
    chk("irq_set", {31'd0, irq}, 32'd1);
    rd(2'd2, 32'h1, "mask_rd");
    wr(2'd3, 32'h1);
    chk("irq_lag_clr", {31'd0, irq}, 32'd1);
    step(1);
    chk("irq_clr", {31'd0, irq}, 32'd0);
    rd(2'd3, 32'h0, "edge_w1c");

    // DATA is read-only; read during write returns the old value; MASK is WIDTH bits
    wr(2'd0, 32'h0);
    rd(2'd0, 32'h2, "data_ro");
    avs_writedata = 32'h3;
    avs_write = 1'b1;
    rd(2'd2, 32'h1, "rd_wr_same");
    avs_write = 1'b0;
    rd(2'd2, 32'h3, "mask_new");
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2, 32'h3, "mask_width");
    wr(2'd2, 32'h1);

    // Rising edge is not captured; then collide set with W1C
    button_in = 2'b11;
    step(15);
    rd(2'd3, 32'h0, "rise_ignored");
    rd(2'd0, 32'h3, "rise_data");
    button_in = 2'b10;
    step(9);
    wr(2'd3, 32'h1);
    rd(2'd3, 32'h1, "set_wins");
    chk("irq_collide", {31'd0, irq}, 32'd1);

    // Reset mid-count discards the partial debounce
    wr(2'd3, 32'h3);
    button_in = 2'b11;
    step(15);
    button_in = 2'b10;
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rst2_irq", {31'd0, irq}, 32'd0);
    chk("rst2_rdata", avs_readdata, 32'd0);
    watch_fall("rst_restart");
    rd(2'd2, 32'h0, "rst2_mask");
    rd(2'd3, 32'h1, "rst2_edge");
    chk("rst2_irq_masked", {31'd0, irq}, 32'd0);

    step(3);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
